montinv_p2: RTL and testbench

MONTINV_P2 -- requirements
Module: montinv_p2

---
 rtl/montinv_p2.sv | 107 ++++++++++
 tb/tb_montinv_p2.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/montinv_p2.sv
// montinv_p2 -- phase-2 correction of an almost-Montgomery inverse.
// Takes x = din (with x < 2p) and exponent k, then either halves
// (k > NBITS) or doubles (k < NBITS) modulo p, |k - NBITS| times, so that
// dout = din * 2^(NBITS-k) mod p. One iteration per clock.
// Optional macro MONTINV_P2_FINAL_RED_EN adds a last conditional subtract
// so that dout < p; without it dout < 2p. Cycle timing is the same either way.
module montinv_p2 #(
  parameter int WIDTH = 256,
  parameter int CWID  = 10,
  parameter int NBITS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [CWID-1:0]  exp,
  input  logic [WIDTH-1:0] mod,
  input  logic             en,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             vld
);

  typedef enum logic [1:0] {IDLE, HALVE, DOUBLE, DONE} state_t;

  // Exponent compare width: wide enough for both exp and NBITS.
  localparam int EW = ((CWID > 31) ? CWID : 31) + 1;

  state_t            state;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  p;
  logic [CWID-1:0]   cnt;

  logic [WIDTH:0]    half_sum;
  logic [WIDTH-1:0]  x_half;
  logic [WIDTH:0]    dbl;
  logic [WIDTH-1:0]  x_dbl;
  logic [WIDTH-1:0]  x_final;
  logic [EW-1:0]     exp_w;
  logic [EW-1:0]     nb_w;

  // Next-x datapath for one halving / doubling step and the output stage.
  always_comb begin
    half_sum = {1'b0, x} + {1'b0, p};
    x_half   = x[0] ? WIDTH'(half_sum >> 1) : (x >> 1);
    dbl      = {x, 1'b0};
    x_dbl    = (dbl >= {1'b0, p}) ? WIDTH'(dbl - {1'b0, p}) : dbl[WIDTH-1:0];
`ifdef MONTINV_P2_FINAL_RED_EN
    x_final  = (x >= p) ? (x - p) : x;
`else
    x_final  = x;
`endif
    exp_w    = EW'(exp);
    nb_w     = EW'(NBITS);
  end

  // Job FSM: load on en (any state), iterate, then publish in DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      x     <= '0;
      p     <= '0;
      cnt   <= '0;
      dout  <= '0;
      busy  <= 1'b0;
      vld   <= 1'b0;
    end else begin
      vld <= 1'b0;
      case (state)
        HALVE: begin
          x   <= x_half;
          cnt <= cnt - 1'b1;
          if (cnt == CWID'(1)) state <= DONE;
        end
        DOUBLE: begin
          x   <= x_dbl;
          cnt <= cnt - 1'b1;
          if (cnt == CWID'(1)) state <= DONE;
        end
        DONE: begin
          dout  <= x_final;
          vld   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: ;
      endcase
      // A new job overrides any iteration in flight; a DONE publish in the
      // same cycle still completes above.
      if (en) begin
        x    <= din;
        p    <= mod;
        busy <= 1'b1;
        if (exp_w > nb_w) begin
          cnt   <= CWID'(exp_w - nb_w);
          state <= HALVE;
        end else if (exp_w < nb_w) begin
          cnt   <= CWID'(nb_w - exp_w);
          state <= DOUBLE;
        end else begin
          cnt   <= '0;
          state <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_montinv_p2.sv
// Self-checking bench for montinv_p2 at WIDTH=8, NBITS=8, mod=251.
module tb_montinv_p2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic [9:0] exp = '0;
  logic [7:0] mod = 8'd251;
  logic       en  = 1'b0;
  logic [7:0] dout;
  logic       busy;
  logic       vld;

  montinv_p2 #(.WIDTH(8), .CWID(10), .NBITS(8)) dut (
    .clk(clk), .rst(rst), .din(din), .exp(exp), .mod(mod), .en(en),
    .dout(dout), .busy(busy), .vld(vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] d;
    int         lat;
    int         start;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [7:0] din;
    logic [9:0] e;
    logic [7:0] d;
    int         lat;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Scoreboard: each vld pops the oldest outstanding job.
  always @(negedge clk) begin
    if (rst && vld) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_vld: got vld with dout=%0d, required no vld", dout);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("dout", int'(dout), int'(e.d));
        check("latency", cyc - e.start, e.lat);
      end
    end
  end

  task automatic wait_drain();
    for (int k = 0; k < 3000 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got %0d jobs outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  // Drive one job, count busy cycles until vld, then let the scoreboard drain.
  task automatic run_vec(input vec_t v);
    int bc;
    @(negedge clk);
    din = v.din;
    exp = v.e;
    en  = 1'b1;
    q.push_back('{v.d, v.lat, cyc + 1});
    @(negedge clk);
    en = 1'b0;
    bc = busy ? 1 : 0;
    for (int k = 0; k < 3000 && !vld; k++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    check("busy_cycles", bc, v.lat);
    wait_drain();
  endtask

  logic [7:0] red252;
  logic [7:0] red253;

  initial begin
`ifdef MONTINV_P2_FINAL_RED_EN
    red252 = 8'd1;
    red253 = 8'd1;
`else
    red252 = 8'd252;
    red253 = 8'd252;
`endif
    tbl[0]  = '{8'd4,   10'd10,   8'd1,   3};
    tbl[1]  = '{8'd3,   10'd9,    8'd127, 2};
    tbl[2]  = '{8'd200, 10'd7,    8'd149, 2};
    tbl[3]  = '{8'd77,  10'd8,    8'd77,  1};
    tbl[4]  = '{8'd252, 10'd8,    red252, 1};
    tbl[5]  = '{8'd1,   10'd6,    8'd4,   3};
    tbl[6]  = '{8'd130, 10'd6,    8'd18,  3};
    tbl[7]  = '{8'd5,   10'd11,   8'd32,  4};
    tbl[8]  = '{8'd5,   10'd9,    8'd128, 2};
    tbl[9]  = '{8'd1,   10'd0,    8'd5,   9};
    tbl[10] = '{8'd253, 10'd9,    red253, 2};
    tbl[11] = '{8'd0,   10'd1023, 8'd0,   1016};
    tbl[12] = '{8'd250, 10'd16,   8'd50,  9};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dout", int'(dout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_vld",  int'(vld),  0);
    rst = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // dout holds in IDLE with en low
    repeat (5) @(negedge clk);
    check("hold_dout", int'(dout), 50);
    check("idle_busy", int'(busy), 0);

    // en coinciding with DONE: first job publishes, second loads
    @(negedge clk);
    din = 8'd3; exp = 10'd9; en = 1'b1;
    q.push_back('{8'd127, 2, cyc + 1});
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    din = 8'd4; exp = 10'd10; en = 1'b1;
    q.push_back('{8'd1, 3, cyc + 1});
    @(negedge clk);
    en = 1'b0;
    wait_drain();

    // en mid-job aborts the first job; only the second produces vld
    @(negedge clk);
    din = 8'd250; exp = 10'd16; en = 1'b1;
    q.push_back('{8'd50, 9, cyc + 1});
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    din = 8'd5; exp = 10'd11; en = 1'b1;
    void'(q.pop_back());
    q.push_back('{8'd32, 4, cyc + 1});
    @(negedge clk);
    en = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);

    // Reset during HALVE: outputs clear next cycle, no vld afterwards
    @(negedge clk);
    din = 8'd4; exp = 10'd10; en = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_dout", int'(dout), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_vld",  int'(vld),  0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
